// File: rtl/cpu7_excp_ctl.sv
// cpu7_excp_ctl: exception/ertn arbiter and flush/redirect sequencer for the execute stage.
// Optional feature macro: CPU7_EXCP_INTR_EN enables the timer interrupt as top-priority source.
module cpu7_excp_ctl #(
  parameter int GRLEN   = 32,
  parameter int ECODE_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_e,
  input  logic [GRLEN-1:0]   ifu_exu_pc_e,
  input  logic               ecl_csr_ale_e,
  input  logic               ecl_csr_illinst_e,
  input  logic               ecl_csr_ertn_e,
  input  logic               csr_ecl_timer_intr,
  input  logic [GRLEN-1:0]   csr_eentry,
  input  logic [GRLEN-1:0]   csr_era,
  output logic               exu_ifu_except,
  output logic               exu_ifu_ertn,
  output logic [ECODE_W-1:0] excp_ecode,
  output logic               ecl_flush,
  output logic               ifu_redirect_valid,
  output logic [GRLEN-1:0]   ifu_redirect_pc,
  input  logic               ifu_redirect_ready,
  output logic               excp_busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] REDIR = 2'd2;
  logic [1:0]         state_q, state_d;
  logic [ECODE_W-1:0] ecode_q, ecode_d;
  logic [GRLEN-1:0]   target_q, target_d;
  logic               hold_q, hold_d;
  logic               intr, any_exc, take;
  logic               unused_pc;
  assign unused_pc = ^ifu_exu_pc_e;
`ifdef CPU7_EXCP_INTR_EN
  assign intr = csr_ecl_timer_intr;
`else
  logic unused_intr;
  assign unused_intr = csr_ecl_timer_intr;
  assign intr = 1'b0;
`endif
  // hold_q suppresses events for the first cycle out of reset
  always_comb begin
    take           = (state_q == IDLE) && valid_e && !rst && !hold_q;
    any_exc        = intr || ecl_csr_ale_e || ecl_csr_illinst_e;
    exu_ifu_except = take && any_exc;
    exu_ifu_ertn   = take && !any_exc && ecl_csr_ertn_e;
    hold_d         = 1'b0;
    ecode_d        = !exu_ifu_except ? ecode_q :
                     intr            ? ECODE_W'(6'h00) :
                     ecl_csr_ale_e   ? ECODE_W'(6'h09) : ECODE_W'(6'h0D);
    target_d       = exu_ifu_except ? csr_eentry :
                     exu_ifu_ertn   ? csr_era    : target_q;
    state_d        = (state_q == IDLE)  ? ((exu_ifu_except || exu_ifu_ertn) ? FLUSH : IDLE) :
                     (state_q == FLUSH) ? REDIR :
                     (state_q == REDIR) ? (ifu_redirect_ready ? IDLE : REDIR) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ecode_q  <= '0;
      target_q <= '0;
      hold_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      ecode_q  <= ecode_d;
      target_q <= target_d;
      hold_q   <= hold_d;
    end
  end
  assign excp_ecode         = ecode_q;
  assign ecl_flush          = (state_q == FLUSH);
  assign ifu_redirect_valid = (state_q == REDIR);
  assign ifu_redirect_pc    = target_q;
  assign excp_busy          = (state_q != IDLE);
endmodule

// File: tb/tb_cpu7_excp_ctl.sv
// tb_cpu7_excp_ctl: directed self-checking bench for cpu7_excp_ctl.
module tb_cpu7_excp_ctl;
  logic        clk = 0, rst = 1;
  logic        valid_e = 0, ale = 0, ill = 0, ertn_e = 0, intr = 0, ready = 0;
  logic [31:0] pc_e = 32'h1C000000, eentry = 0, era = 0;
  logic        except, ertn, flush, rv, busy;
  logic [5:0]  ecode;
  logic [31:0] rpc;
  int passed = 0, total = 0;
  cpu7_excp_ctl dut (
    .clk(clk), .rst(rst), .valid_e(valid_e), .ifu_exu_pc_e(pc_e),
    .ecl_csr_ale_e(ale), .ecl_csr_illinst_e(ill), .ecl_csr_ertn_e(ertn_e),
    .csr_ecl_timer_intr(intr), .csr_eentry(eentry), .csr_era(era),
    .exu_ifu_except(except), .exu_ifu_ertn(ertn), .excp_ecode(ecode),
    .ecl_flush(flush), .ifu_redirect_valid(rv), .ifu_redirect_pc(rpc),
    .ifu_redirect_ready(ready), .excp_busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask
  task automatic clr;
    valid_e = 0; ale = 0; ill = 0; ertn_e = 0; intr = 0;
  endtask
  initial begin
    logic [31:0] prio_exp;
`ifdef CPU7_EXCP_INTR_EN
    prio_exp = 32'h00;
`else
    prio_exp = 32'h09;
`endif
    tick; tick;
    rst = 0;
    chk("rst_busy", busy, 0); chk("rst_ecode", ecode, 0);
    chk("rst_flush", flush, 0); chk("rst_rv", rv, 0); chk("rst_pc", rpc, 0);
    tick;
    // ALE with immediate ready
    valid_e = 1; ale = 1; eentry = 32'h1C000100; ready = 1; #1;
    chk("ale_strobe", except, 1); chk("ale_no_ertn", ertn, 0);
    tick; clr;
    chk("ale_ecode", ecode, 32'h09); chk("ale_flush", flush, 1); chk("ale_rv_t1", rv, 0);
    tick;
    chk("ale_rv", rv, 1); chk("ale_pc", rpc, 32'h1C000100); chk("ale_flush_off", flush, 0);
    tick;
    chk("ale_idle", busy, 0);
    // interrupt + ALE + illinst
    valid_e = 1; intr = 1; ale = 1; ill = 1; #1;
    chk("prio_strobe", except, 1);
    tick; clr; chk("prio_ecode", ecode, prio_exp);
    tick; tick; chk("prio_idle", busy, 0);
    // illegal instruction alone
    valid_e = 1; ill = 1; #1;
    tick; clr; chk("ill_ecode", ecode, 32'h0D);
    tick; tick;
    // ertn
    era = 32'h1C000040; valid_e = 1; ertn_e = 1; #1;
    chk("ertn_strobe", ertn, 1); chk("ertn_no_exc", except, 0);
    tick; clr; chk("ertn_ecode_kept", ecode, 32'h0D); chk("ertn_flush", flush, 1);
    tick; chk("ertn_pc", rpc, 32'h1C000040);
    tick;
    // ertn + ALE
    valid_e = 1; ertn_e = 1; ale = 1; #1;
    chk("ertnale_exc", except, 1); chk("ertnale_no_ertn", ertn, 0);
    tick; clr; chk("ertnale_ecode", ecode, 32'h09);
    tick; tick;
    // backpressure with stable redirect, EENTRY change and new event ignored
    ready = 0; eentry = 32'h1C000200; valid_e = 1; ill = 1; #1;
    tick; clr; tick;
    eentry = 32'hDEADBEEF; valid_e = 1; ale = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rv", rv, 1); chk("bp_pc", rpc, 32'h1C000200); chk("bp_no_strobe", except, 0);
      tick;
    end
    ready = 1; #1;
    chk("xfer_no_strobe", except, 0); chk("xfer_rv", rv, 1);
    tick; clr;
    chk("xfer_idle", busy, 0); chk("xfer_rv_off", rv, 0);
    // reset mid-REDIR
    ready = 0; valid_e = 1; ale = 1; eentry = 32'h1C000300; #1;
    tick; tick;
    chk("pre_rst_rv", rv, 1);
    rst = 1; #1;
    chk("rst_cycle_no_strobe", except, 0);
    tick; rst = 0; #1;
    chk("mrst_rv", rv, 0); chk("mrst_busy", busy, 0); chk("mrst_ecode", ecode, 0);
    chk("mrst_after_no_strobe", except, 0);
    tick; clr;
    // valid_e low gates the event
    ill = 1; ready = 1; #1;
    chk("nv_no_strobe", except, 0);
    tick; chk("nv_idle", busy, 0); chk("nv_flush", flush, 0);
    clr;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
